// File: rtl/jbi_rdma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jbi_rdma_pkg
// Purpose  : Shared constants, entry layout and assembler state encoding for
//            the L2 RDMA read-return receiver.
// Contents : NUM_WORDS  - 32-bit data beats per return (power of 2, >= 2)
//            CTAG_W     - ctag width carried in the header beat
//            LINE_W     - assembled line width in bits
//            CNT_W      - beat counter width
//            rtn_entry_t, rcv_state_t
// Revision : 1.0 - initial release
// ============================================================================
package jbi_rdma_pkg;

  localparam int NUM_WORDS = 16;
  localparam int CTAG_W    = 15;
  localparam int LINE_W    = 32 * NUM_WORDS;
  localparam int CNT_W     = $clog2(NUM_WORDS);

  typedef struct packed {
    logic [CTAG_W-1:0] ctag;
    logic [LINE_W-1:0] data;
    logic              ue;
  } rtn_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DATA = 1'b1
  } rcv_state_t;

endpackage
`default_nettype wire

// File: rtl/jbi_rdma_rtn_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : jbi_rdma_rtn_fifo2
// Purpose  : 2-entry FIFO of return entries with a registered head. A push
//            and a pop in the same cycle are honoured at every occupancy,
//            including full. A push into a full FIFO without a pop is dropped
//            and reported on 'drop'.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            push, push_entry   - write strobe and entry
//            pop                - read strobe (ignored when empty)
//            head               - oldest entry (registered)
//            full, empty        - occupancy flags
//            drop               - push lost because the FIFO was full
// Revision : 1.0 - initial release
// ============================================================================
module jbi_rdma_rtn_fifo2
  import jbi_rdma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rtn_entry_t push_entry,
  input  logic       pop,
  output rtn_entry_t head,
  output logic       full,
  output logic       empty,
  output logic       drop
);

  rtn_entry_t head_q;
  rtn_entry_t tail_q;
  logic [1:0] cnt_q;
  logic       pop_ok;

  assign empty  = (cnt_q == 2'd0);
  assign full   = (cnt_q == 2'd2);
  assign pop_ok = pop & ~empty;
  assign drop   = push & full & ~pop_ok;
  assign head   = head_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_q <= push_entry;
            cnt_q  <= 2'd1;
          end else if (cnt_q == 2'd1) begin
            tail_q <= push_entry;
            cnt_q  <= 2'd2;
          end
          // full and no pop: entry dropped, storage untouched
        end
        2'b01: begin
          if (cnt_q == 2'd2) head_q <= tail_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new entry goes behind whatever remains
          if (cnt_q == 2'd1) begin
            head_q <= push_entry;
          end else begin
            head_q <= tail_q;
            tail_q <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/jbi_l2_rdma_rtn_rcv.sv
`default_nettype none
// ============================================================================
// Module   : jbi_l2_rdma_rtn_rcv
// Purpose  : Receives the L2-bank RDMA read-return stream (ctag header then
//            NUM_WORDS data beats), assembles line-sized entries, buffers them
//            in a 2-entry FIFO and hands them out over valid/ready. One credit
//            pulse is returned per entry consumed. Protocol violations are
//            latched in sticky flags.
// Ports    : rclk, rst            - clock, synchronous active-high reset
//            scbuf_jbi_ctag_vld   - header strobe (ctag in data[CTAG_W-1:0])
//            scbuf_jbi_data       - header/data beat
//            scbuf_jbi_ue_err     - uncorrectable error for the current beat
//            rtn_vld / rtn_rdy    - head entry handshake
//            rtn_ctag/data/ue     - head entry contents
//            rtn_credit           - one-cycle pulse per entry popped
//            rcv_proto_err        - sticky: header during a data phase
//            rcv_ovf_err          - sticky: entry dropped on a full buffer
// Revision : 1.0 - initial release
// ============================================================================
module jbi_l2_rdma_rtn_rcv
  import jbi_rdma_pkg::*;
(
  input  logic              rclk,
  input  logic              rst,
  input  logic              scbuf_jbi_ctag_vld,
  input  logic [31:0]       scbuf_jbi_data,
  input  logic              scbuf_jbi_ue_err,
  output logic              rtn_vld,
  input  logic              rtn_rdy,
  output logic [CTAG_W-1:0] rtn_ctag,
  output logic [LINE_W-1:0] rtn_data,
  output logic              rtn_ue,
  output logic              rtn_credit,
  output logic              rcv_proto_err,
  output logic              rcv_ovf_err
);

  rcv_state_t        state_q;
  rcv_state_t        state_d;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [CTAG_W-1:0] asm_ctag_q;
  logic [LINE_W-1:0] asm_data_q;
  logic              ue_acc_q;

  logic              last_beat;
  logic              hdr_in_data;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_drop;
  rtn_entry_t        push_entry;
  rtn_entry_t        head;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge rclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    last_beat   = 1'b0;
    hdr_in_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (scbuf_jbi_ctag_vld) state_d = DATA;
      end
      DATA: begin
        if (scbuf_jbi_ctag_vld) begin
          // abandon the partial line and restart on the new ctag
          hdr_in_data = 1'b1;
        end else if (beat_cnt_q == CNT_W'(NUM_WORDS - 1)) begin
          last_beat = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------- assembly
  always_ff @(posedge rclk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      asm_ctag_q <= '0;
      asm_data_q <= '0;
      ue_acc_q   <= 1'b0;
    end else if (scbuf_jbi_ctag_vld) begin
      asm_ctag_q <= scbuf_jbi_data[CTAG_W-1:0];
      beat_cnt_q <= '0;
      ue_acc_q   <= 1'b0;
    end else if (state_q == DATA) begin
      asm_data_q[{beat_cnt_q, 5'b0} +: 32] <= scbuf_jbi_data;
      ue_acc_q   <= ue_acc_q | scbuf_jbi_ue_err;
      beat_cnt_q <= beat_cnt_q + 1'b1;  // wraps to 0 after the last beat
    end
  end

  // The final beat bypasses the assembly register so the entry is written
  // into the FIFO on the edge that closes the last beat.
  always_comb begin
    push_entry.ctag = asm_ctag_q;
    push_entry.data = {scbuf_jbi_data, asm_data_q[LINE_W-33:0]};
    push_entry.ue   = ue_acc_q | scbuf_jbi_ue_err;
  end

  // ------------------------------------------------------------ buffer
  assign pop = rtn_vld & rtn_rdy;

  jbi_rdma_rtn_fifo2 u_fifo (
    .clk        (rclk),
    .rst        (rst),
    .push       (last_beat),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .drop       (fifo_drop)
  );

  assign rtn_vld  = ~fifo_empty;
  assign rtn_ctag = head.ctag;
  assign rtn_data = head.data;
  assign rtn_ue   = head.ue;

  // ------------------------------------------------ credit and errors
  always_ff @(posedge rclk) begin
    if (rst) begin
      rtn_credit    <= 1'b0;
      rcv_proto_err <= 1'b0;
      rcv_ovf_err   <= 1'b0;
    end else begin
      rtn_credit    <= pop;
      rcv_proto_err <= rcv_proto_err | hdr_in_data;
      rcv_ovf_err   <= rcv_ovf_err | fifo_drop;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jbi_l2_rdma_rtn_rcv.sv
`default_nettype none
// ============================================================================
// Module   : tb_jbi_l2_rdma_rtn_rcv
// Purpose  : Self-checking bench for jbi_l2_rdma_rtn_rcv. Stimulus pushes the
//            expected entries into a scoreboard queue; a monitor pops and
//            compares each entry the DUT hands over, and checks that every
//            credit pulse follows a pop by exactly one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jbi_l2_rdma_rtn_rcv;
  import jbi_rdma_pkg::*;

  logic              rclk = 1'b0;
  logic              rst;
  logic              ctag_vld;
  logic [31:0]       data;
  logic              ue_err;
  logic              rtn_vld;
  logic              rtn_rdy;
  logic [CTAG_W-1:0] rtn_ctag;
  logic [LINE_W-1:0] rtn_data;
  logic              rtn_ue;
  logic              rtn_credit;
  logic              rcv_proto_err;
  logic              rcv_ovf_err;

  always #5 rclk = ~rclk;

  jbi_l2_rdma_rtn_rcv dut (
    .rclk               (rclk),
    .rst                (rst),
    .scbuf_jbi_ctag_vld (ctag_vld),
    .scbuf_jbi_data     (data),
    .scbuf_jbi_ue_err   (ue_err),
    .rtn_vld            (rtn_vld),
    .rtn_rdy            (rtn_rdy),
    .rtn_ctag           (rtn_ctag),
    .rtn_data           (rtn_data),
    .rtn_ue             (rtn_ue),
    .rtn_credit         (rtn_credit),
    .rcv_proto_err      (rcv_proto_err),
    .rcv_ovf_err        (rcv_ovf_err)
  );

  typedef struct {
    logic [CTAG_W-1:0] ctag;
    logic [LINE_W-1:0] data;
    logic              ue;
  } exp_t;

  exp_t sb_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   credit_cnt = 0;
  logic prev_pop   = 1'b0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [LINE_W-1:0] make_line(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int i = 0; i < NUM_WORDS; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic expect_entry(input logic [CTAG_W-1:0] ctag,
                              input logic [31:0] base, input logic ue);
    exp_t e;
    e.ctag = ctag;
    e.data = make_line(base);
    e.ue   = ue;
    sb_q.push_back(e);
  endtask

  // header then nbeats beats of base+i; ue_err on beat ue_beat (-1: none);
  // rdy_last raises rtn_rdy together with the final beat
  task automatic send(input logic [CTAG_W-1:0] ctag, input logic [31:0] base,
                      input int nbeats, input int ue_beat, input bit rdy_last);
    @(posedge rclk); #1;
    ctag_vld = 1'b1;
    data     = 32'(ctag);
    ue_err   = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      @(posedge rclk); #1;
      ctag_vld = 1'b0;
      data     = base + 32'(i);
      ue_err   = (i == ue_beat);
      if (rdy_last && i == nbeats - 1) rtn_rdy = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge rclk); #1;
      ctag_vld = 1'b0;
      data     = 32'hDEAD_BEEF;
      ue_err   = 1'b0;
    end
  endtask

  // ------------------------------------------------------------ monitor
  always @(negedge rclk) begin : mon
    exp_t e;
    if (rst) begin
      prev_pop = 1'b0;
    end else begin
      if (rtn_credit || prev_pop) check("credit_pulse", LINE_W'(rtn_credit), LINE_W'(prev_pop));
      if (rtn_credit) credit_cnt++;
      if (rtn_vld && rtn_rdy) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_entry actual ctag=%0h required no entry", rtn_ctag);
        end else begin
          e = sb_q.pop_front();
          check("entry_ctag", LINE_W'(rtn_ctag), LINE_W'(e.ctag));
          check("entry_data", rtn_data, e.data);
          check("entry_ue", LINE_W'(rtn_ue), LINE_W'(e.ue));
        end
      end
      prev_pop = rtn_vld && rtn_rdy;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ----------------------------------------------------------- stimulus
  initial begin : stim
    int c0;
    rst      = 1'b1;
    ctag_vld = 1'b0;
    data     = '0;
    ue_err   = 1'b0;
    rtn_rdy  = 1'b0;
    repeat (2) @(posedge rclk);
    #1 rst = 1'b0;
    @(negedge rclk);
    check("rst_vld", LINE_W'(rtn_vld), '0);
    check("rst_ctag", LINE_W'(rtn_ctag), '0);
    check("rst_data", rtn_data, '0);
    check("rst_ue", LINE_W'(rtn_ue), '0);
    check("rst_credit", LINE_W'(rtn_credit), '0);
    check("rst_errs", LINE_W'({rcv_proto_err, rcv_ovf_err}), '0);

    // single return with latency check; stray data in IDLE must be ignored
    idle(3);
    rtn_rdy = 1'b1;
    expect_entry(15'h1A5C, 32'h0, 1'b0);
    send(15'h1A5C, 32'h0, NUM_WORDS, -1, 1'b0);
    @(negedge rclk);
    check("lat_last_beat_vld", LINE_W'(rtn_vld), '0);
    @(negedge rclk);
    check("lat_next_cycle_vld", LINE_W'(rtn_vld), LINE_W'(1));
    idle(4);

    // UE accumulation then a clean return
    expect_entry(15'h0123, 32'h100, 1'b1);
    send(15'h0123, 32'h100, NUM_WORDS, 7, 1'b0);
    expect_entry(15'h0124, 32'h200, 1'b0);
    send(15'h0124, 32'h200, NUM_WORDS, -1, 1'b0);
    idle(4);
    check("no_proto_yet", LINE_W'(rcv_proto_err), '0);

    // push and pop on the same cycle while full
    rtn_rdy = 1'b0;
    expect_entry(15'h0A01, 32'h1000, 1'b0);
    send(15'h0A01, 32'h1000, NUM_WORDS, -1, 1'b0);
    expect_entry(15'h0A02, 32'h2000, 1'b0);
    send(15'h0A02, 32'h2000, NUM_WORDS, -1, 1'b0);
    expect_entry(15'h0A03, 32'h3000, 1'b0);
    send(15'h0A03, 32'h3000, NUM_WORDS, -1, 1'b1);
    idle(6);
    check("pushpop_full_no_ovf", LINE_W'(rcv_ovf_err), '0);
    check("pushpop_drained", LINE_W'(rtn_vld), '0);

    // header during data: partial line A discarded, B delivered
    send(15'h0AAA, 32'h400, 5, -1, 1'b0);
    expect_entry(15'h0BBB, 32'h500, 1'b0);
    send(15'h0BBB, 32'h500, NUM_WORDS, -1, 1'b0);
    idle(4);
    check("proto_err_set", LINE_W'(rcv_proto_err), LINE_W'(1));

    // three back-to-back returns under backpressure: third is dropped
    rtn_rdy = 1'b0;
    expect_entry(15'h0011, 32'h11000, 1'b0);
    send(15'h0011, 32'h11000, NUM_WORDS, -1, 1'b0);
    expect_entry(15'h0022, 32'h22000, 1'b0);
    send(15'h0022, 32'h22000, NUM_WORDS, -1, 1'b0);
    send(15'h0033, 32'h33000, NUM_WORDS, -1, 1'b0);
    idle(3);
    @(negedge rclk);
    check("ovf_err_set", LINE_W'(rcv_ovf_err), LINE_W'(1));
    check("ovf_head_held", LINE_W'(rtn_ctag), LINE_W'(15'h0011));
    c0 = credit_cnt;
    rtn_rdy = 1'b1;
    idle(6);
    check("ovf_credits", LINE_W'(credit_cnt - c0), LINE_W'(2));
    check("ovf_drained", LINE_W'(rtn_vld), '0);

    // reset mid-return with one entry buffered
    rtn_rdy = 1'b0;
    send(15'h0777, 32'h7000, NUM_WORDS, -1, 1'b0);
    send(15'h0999, 32'h9000, 8, -1, 1'b0);
    @(posedge rclk); #1;
    rst      = 1'b1;
    ctag_vld = 1'b0;
    @(posedge rclk); #1;
    rst = 1'b0;
    @(negedge rclk);
    check("mid_rst_vld", LINE_W'(rtn_vld), '0);
    check("mid_rst_credit", LINE_W'(rtn_credit), '0);
    check("mid_rst_errs", LINE_W'({rcv_proto_err, rcv_ovf_err}), '0);
    c0 = credit_cnt;
    rtn_rdy = 1'b1;
    expect_entry(15'h0888, 32'h8000, 1'b0);
    send(15'h0888, 32'h8000, NUM_WORDS, -1, 1'b0);
    idle(5);
    check("post_rst_credit", LINE_W'(credit_cnt - c0), LINE_W'(1));

    check("sb_empty", LINE_W'(sb_q.size()), '0);
    check("total_credits", LINE_W'(credit_cnt), LINE_W'(10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
